// File: rtl/opl_bus_capture_if.sv
// Host strobe bus and register-file write port of opl_bus_capture.
// The slave modport is the capture block; the master modport is the host/register-file side.
interface opl_bus_capture_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BANK_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
);
    logic                              bus_strobe_i;
    logic [BANK_BITS:0]                bus_a_i;
    logic [DATA_WIDTH-1:0]             bus_d_i;
    logic                              reg_valid_o;
    logic                              reg_ready_i;
    logic [BANK_BITS+ADDR_WIDTH-1:0]   reg_addr_o;
    logic [DATA_WIDTH-1:0]             reg_data_o;
    logic [$clog2(FIFO_DEPTH):0]       fifo_level_o;
    logic                              overflow_o;
    logic                              clear_ovf_i;

    modport slave (
        input  bus_strobe_i, bus_a_i, bus_d_i, reg_ready_i, clear_ovf_i,
        output reg_valid_o, reg_addr_o, reg_data_o, fifo_level_o, overflow_o
    );

    modport master (
        output bus_strobe_i, bus_a_i, bus_d_i, reg_ready_i, clear_ovf_i,
        input  reg_valid_o, reg_addr_o, reg_data_o, fifo_level_o, overflow_o
    );
endinterface

// File: rtl/opl_bus_capture.sv
// Captures OPL3-style host writes from an asynchronous strobe bus, decodes address/data
// phases per bank and queues completed register writes in a FIFO with overflow status.
module opl_bus_capture #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned BANK_BITS   = 1,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    opl_bus_capture_if.slave bus
);
    localparam int unsigned NumBanks = 1 << BANK_BITS;
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW     = PtrW + 1;
    localparam int unsigned EntW     = BANK_BITS + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned FillMax  = SYNC_STAGES + 1;
    localparam int unsigned FillW    = $clog2(FillMax + 1);

    logic                  r_strobe_sync [SYNC_STAGES];
    logic [BANK_BITS:0]    r_a_sync      [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] r_d_sync      [SYNC_STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_strobe_sync[i] <= 1'b0;
                r_a_sync[i]      <= '0;
                r_d_sync[i]      <= '0;
            end
        end else begin
            r_strobe_sync[0] <= bus.bus_strobe_i;
            r_a_sync[0]      <= bus.bus_a_i;
            r_d_sync[0]      <= bus.bus_d_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_strobe_sync[i] <= r_strobe_sync[i-1];
                r_a_sync[i]      <= r_a_sync[i-1];
                r_d_sync[i]      <= r_d_sync[i-1];
            end
        end
    end

    // Edge detection stays disarmed until the synchroniser and delay flop hold real pin
    // samples, so a strobe already high at reset release is not taken as an edge.
    logic [FillW-1:0]      r_fill;
    logic                  r_strobe_dly;
    logic                  r_ev;
    logic [BANK_BITS:0]    r_ev_a;
    logic [DATA_WIDTH-1:0] r_ev_d;
    logic                  w_sync_strobe;
    logic                  w_filled;
    logic                  w_edge;

    assign w_sync_strobe = r_strobe_sync[SYNC_STAGES-1];
    assign w_filled      = (r_fill == FillW'(FillMax));
    assign w_edge        = w_filled & w_sync_strobe & ~r_strobe_dly;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fill       <= '0;
            r_strobe_dly <= 1'b0;
            r_ev         <= 1'b0;
            r_ev_a       <= '0;
            r_ev_d       <= '0;
        end else begin
            if (!w_filled) r_fill <= r_fill + FillW'(1);
            r_strobe_dly <= w_sync_strobe;
            r_ev         <= w_edge;
            r_ev_a       <= r_a_sync[SYNC_STAGES-1];
            r_ev_d       <= r_d_sync[SYNC_STAGES-1];
        end
    end

    logic [BANK_BITS-1:0]  w_bank;
    logic                  w_is_data;
    logic [ADDR_WIDTH-1:0] r_addr_latch [NumBanks];

    assign w_bank    = r_ev_a[BANK_BITS:1];
    assign w_is_data = r_ev_a[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumBanks); i++) r_addr_latch[i] <= '0;
        end else if (r_ev && !w_is_data) begin
            r_addr_latch[w_bank] <= r_ev_d[ADDR_WIDTH-1:0];
        end
    end

    logic [EntW-1:0] r_mem [FIFO_DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [LvlW-1:0] r_level;
    logic            r_overflow;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_accept;
    logic            w_drop;
    logic [EntW-1:0] w_entry;

    assign w_push   = r_ev & w_is_data;
    assign w_pop    = bus.reg_valid_o & bus.reg_ready_i;
    assign w_full   = (r_level == LvlW'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign w_accept = w_push & (~w_full | w_pop);
    assign w_drop   = w_push & w_full & ~w_pop;
    assign w_entry  = {w_bank, r_addr_latch[w_bank], r_ev_d};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= w_entry;
                r_wr_ptr        <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
            if (w_accept && !w_pop)      r_level <= r_level + LvlW'(1);
            else if (!w_accept && w_pop) r_level <= r_level - LvlW'(1);
            if (w_drop)                  r_overflow <= 1'b1;
            else if (bus.clear_ovf_i)    r_overflow <= 1'b0;
        end
    end

    assign bus.reg_valid_o              = (r_level != '0);
    assign {bus.reg_addr_o, bus.reg_data_o} = r_mem[r_rd_ptr];
    assign bus.fifo_level_o             = r_level;
    assign bus.overflow_o               = r_overflow;
endmodule

// File: tb/tb_opl_bus_capture.sv
// Directed, table-driven bench for opl_bus_capture with default parameters
// (8-bit data/address, 2 banks, 16-entry FIFO, 2 synchroniser stages).
module tb_opl_bus_capture;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    opl_bus_capture_if #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .BANK_BITS(1), .FIFO_DEPTH(16)
    ) ifc ();

    opl_bus_capture #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .BANK_BITS(1), .FIFO_DEPTH(16), .SYNC_STAGES(2)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (ifc)
    );

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
        bit         push;
        logic [8:0] ea;
        logic [7:0] ed;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One host write; optionally checks valid is low 3 edges after the strobe and
    // equals exp_push on the 4th (SYNC_STAGES+2), valid only with an empty FIFO.
    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input bit chk_lat,
                             input bit exp_push, input string nm);
        logic v3, v4;
        ifc.bus_a_i = a;
        ifc.bus_d_i = d;
        repeat (3) cyc();
        ifc.bus_strobe_i = 1'b1;
        repeat (3) cyc();
        v3 = ifc.reg_valid_o;
        ifc.bus_strobe_i = 1'b0;
        cyc();
        v4 = ifc.reg_valid_o;
        repeat (2) cyc();
        if (chk_lat) check({nm, " latency"}, {30'd0, v3, v4}, {30'd0, 1'b0, exp_push});
    endtask

    // Write timed so the FIFO push lands on the same edge as a pop (use_ready) or a clear.
    task automatic aligned_write(input logic [7:0] d, input bit use_ready);
        ifc.bus_a_i = 2'b01;
        ifc.bus_d_i = d;
        repeat (3) cyc();
        ifc.bus_strobe_i = 1'b1;
        repeat (3) cyc();
        ifc.bus_strobe_i = 1'b0;
        if (use_ready) ifc.reg_ready_i = 1'b1;
        else           ifc.clear_ovf_i = 1'b1;
        cyc();
        ifc.reg_ready_i = 1'b0;
        ifc.clear_ovf_i = 1'b0;
        repeat (3) cyc();
    endtask

    task automatic pop_check(input string nm, input logic [8:0] ea, input logic [7:0] ed);
        check({nm, " valid"}, {31'd0, ifc.reg_valid_o}, 32'd1);
        check({nm, " addr"}, {23'd0, ifc.reg_addr_o}, {23'd0, ea});
        check({nm, " data"}, {24'd0, ifc.reg_data_o}, {24'd0, ed});
        ifc.reg_ready_i = 1'b1;
        cyc();
        ifc.reg_ready_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b01, 8'h7F, 1'b1, 9'h000, 8'h7F};
        vecs[1] = '{2'b00, 8'h20, 1'b0, 9'h000, 8'h00};
        vecs[2] = '{2'b01, 8'hA5, 1'b1, 9'h020, 8'hA5};
        vecs[3] = '{2'b10, 8'h05, 1'b0, 9'h000, 8'h00};
        vecs[4] = '{2'b00, 8'hB0, 1'b0, 9'h000, 8'h00};
        vecs[5] = '{2'b11, 8'h01, 1'b1, 9'h105, 8'h01};
        vecs[6] = '{2'b01, 8'h20, 1'b1, 9'h0B0, 8'h20};
        vecs[7] = '{2'b01, 8'h33, 1'b1, 9'h0B0, 8'h33};
        vecs[8] = '{2'b11, 8'hC4, 1'b1, 9'h105, 8'hC4};

        ifc.bus_strobe_i = 1'b0;
        ifc.bus_a_i      = '0;
        ifc.bus_d_i      = '0;
        ifc.reg_ready_i  = 1'b0;
        ifc.clear_ovf_i  = 1'b0;
        repeat (3) cyc();
        check("reset valid", {31'd0, ifc.reg_valid_o}, 32'd0);
        check("reset addr", {23'd0, ifc.reg_addr_o}, 32'd0);
        check("reset data", {24'd0, ifc.reg_data_o}, 32'd0);
        check("reset level", {27'd0, ifc.fifo_level_o}, 32'd0);
        check("reset ovf", {31'd0, ifc.overflow_o}, 32'd0);
        rst = 1'b0;
        repeat (4) cyc();

        for (int i = 0; i < 9; i++) begin
            bus_write(vecs[i].a, vecs[i].d, 1'b1, vecs[i].push, $sformatf("vec%0d", i));
            if (vecs[i].push) pop_check($sformatf("vec%0d", i), vecs[i].ea, vecs[i].ed);
        end
        check("table drained", {31'd0, ifc.reg_valid_o}, 32'd0);

        // Overflow: 17 writes into 16 entries, bank 0 latch still 0xB0.
        for (int i = 0; i < 17; i++) begin
            bus_write(2'b01, 8'(i), 1'b0, 1'b0, "ovf");
            if (i == 15) check("ovf not yet", {31'd0, ifc.overflow_o}, 32'd0);
        end
        check("ovf level", {27'd0, ifc.fifo_level_o}, 32'd16);
        check("ovf set", {31'd0, ifc.overflow_o}, 32'd1);
        for (int i = 0; i < 16; i++) pop_check($sformatf("ovf pop%0d", i), 9'h0B0, 8'(i));
        check("ovf 17th absent", {31'd0, ifc.reg_valid_o}, 32'd0);
        check("ovf sticky", {31'd0, ifc.overflow_o}, 32'd1);
        ifc.clear_ovf_i = 1'b1;
        cyc();
        ifc.clear_ovf_i = 1'b0;
        check("ovf cleared", {31'd0, ifc.overflow_o}, 32'd0);

        // Full FIFO: push aligned with a pop, then a drop aligned with a clear.
        for (int i = 0; i < 16; i++) bus_write(2'b01, 8'(8'h40 + i), 1'b0, 1'b0, "full");
        check("full level", {27'd0, ifc.fifo_level_o}, 32'd16);
        aligned_write(8'h99, 1'b1);
        check("pushpop level", {27'd0, ifc.fifo_level_o}, 32'd16);
        check("pushpop no ovf", {31'd0, ifc.overflow_o}, 32'd0);
        aligned_write(8'hEE, 1'b0);
        check("drop+clear ovf", {31'd0, ifc.overflow_o}, 32'd1);
        check("drop level", {27'd0, ifc.fifo_level_o}, 32'd16);
        for (int i = 1; i < 16; i++) pop_check($sformatf("full pop%0d", i), 9'h0B0, 8'(8'h40 + i));
        pop_check("full last", 9'h0B0, 8'h99);
        check("full drained", {31'd0, ifc.reg_valid_o}, 32'd0);

        // Reset with 5 queued entries and the strobe held high across release.
        bus_write(2'b00, 8'h77, 1'b0, 1'b0, "rst addr");
        for (int i = 0; i < 5; i++) bus_write(2'b01, 8'(i), 1'b0, 1'b0, "rst data");
        check("rst pre level", {27'd0, ifc.fifo_level_o}, 32'd5);
        ifc.bus_a_i = 2'b01;
        ifc.bus_d_i = 8'h5A;
        ifc.bus_strobe_i = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst async level", {27'd0, ifc.fifo_level_o}, 32'd0);
        check("rst async valid", {31'd0, ifc.reg_valid_o}, 32'd0);
        check("rst async ovf", {31'd0, ifc.overflow_o}, 32'd0);
        repeat (3) cyc();
        rst = 1'b0;
        repeat (10) cyc();
        check("rst held strobe level", {27'd0, ifc.fifo_level_o}, 32'd0);
        check("rst held strobe valid", {31'd0, ifc.reg_valid_o}, 32'd0);
        ifc.bus_strobe_i = 1'b0;
        repeat (3) cyc();
        ifc.bus_strobe_i = 1'b1;
        repeat (3) cyc();
        ifc.bus_strobe_i = 1'b0;
        repeat (3) cyc();
        check("rst new edge level", {27'd0, ifc.fifo_level_o}, 32'd1);
        pop_check("rst new edge", 9'h000, 8'h5A);
        bus_write(2'b11, 8'h7F, 1'b1, 1'b1, "rst bank1");
        pop_check("rst bank1", 9'h100, 8'h7F);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/opl_bus_capture.md
Name: opl_bus_capture

Overview:
- Captures OPL3-style host writes from an asynchronous external strobe bus (GPIO) into the OPL clock domain.
- Decodes address and data phases with a per-bank address latch.
- Queues completed register writes in a FIFO and presents them to the register file over a valid/ready port.
- Parametrised successor to the single-bank, strobe-clocked register latch: adds synchronisation, N banks, buffering, backpressure and overflow status.

Parameters:
- DATA_WIDTH, 8, width of the host data bus and register data.
- ADDR_WIDTH, 8, register address width within one bank.
- BANK_BITS, 1, bank select bits; number of banks is 2^BANK_BITS.
- FIFO_DEPTH, 16, write queue entries; power of two, at least 2.
- SYNC_STAGES, 2, synchroniser flops on strobe, address and data inputs; at least 2.

Ports:
- clk_i  in  1  OPL core clock.
- rst_i  in  1  asynchronous, active-high reset.
- bus_strobe_i  in  1  asynchronous host write strobe; rising edge = write.
- bus_a_i  in  BANK_BITS+1  bit0: 0 = address phase, 1 = data phase; upper bits = bank.
- bus_d_i  in  DATA_WIDTH  host data.
- reg_valid_o  out  1  FIFO head is valid.
- reg_ready_i  in  1  register file accepts the head.
- reg_addr_o  out  BANK_BITS+ADDR_WIDTH  {bank, address} of head.
- reg_data_o  out  DATA_WIDTH  data of head.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current entry count.
- overflow_o  out  1  sticky; a data write was dropped.
- clear_ovf_i  in  1  clears overflow_o.

Behaviour:
- Reset (async assert, sync release): all synchroniser flops, address latches, FIFO pointers and outputs go to 0. Outputs: reg_valid_o=0, reg_addr_o=0, reg_data_o=0, fifo_level_o=0, overflow_o=0.
- Reset mid-operation discards FIFO contents and latches. A strobe already high at release is not an edge; the next rising edge is.
- Synchronisation: bus_strobe_i, bus_a_i and bus_d_i each pass through SYNC_STAGES flops. The host holds a/d stable from at least SYNC_STAGES+1 clk_i cycles before the strobe rises until 1 cycle after.
- Edge detect: one extra flop on the synced strobe. Event cycle E = synced high and delayed low. Detection occurs SYNC_STAGES+1 cycles after the pin edge. A strobe high for fewer than 1 clk_i period may be missed; a bench must not rely on it.
- Address phase (a[0]=0) at E: addr_latch[bank] <= d[ADDR_WIDTH-1:0]. Each bank has an independent latch. No FIFO action.
- Data phase (a[0]=1) at E: push {bank, addr_latch[bank], d}. A data phase with no prior address phase uses latch value 0.
- Address phase and data phase in the same event cannot occur; one a[0] value per event.
- FIFO: registered head; reg_valid_o = (level != 0).
  - A push into an empty FIFO at E gives reg_valid_o=1 at E+1 with the head outputs stable.
  - Pop occurs when reg_valid_o & reg_ready_i. The next head appears the following cycle.
  - Head outputs hold while reg_valid_o=1 and reg_ready_i=0.
  - Push and pop in the same cycle: level unchanged. When full, the simultaneous pop frees a slot and the push is accepted.
  - Push when full with no pop: entry dropped, overflow_o <= 1, FIFO unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level_o is updated registered at E+1 (push) or the cycle after the pop.
- overflow_o: sticky until clear_ovf_i=1. If a drop and a clear happen in the same cycle, set wins.
- No reads or status returned to the host; the block is write-only.

Test Plan:
- Address phase a=0 d=0x20, then data phase a=1 d=0xA5 -> single pop: reg_addr_o=0x020, reg_data_o=0xA5. reg_valid_o rises exactly SYNC_STAGES+2 cycles after the data strobe pin edge.
- Bank 1 address phase a=2'b10 d=0x05; bank 0 address phase d=0xB0; then bank 1 data phase d=0x01 and bank 0 data phase d=0x20 -> pops 0x105/0x01 then 0x0B0/0x20, confirming independent latches.
- reg_ready_i=0, 17 data writes with FIFO_DEPTH=16 -> fifo_level_o=16, overflow_o=1. Then ready=1 -> exactly 16 pops in order, with the 17th value absent.
- FIFO full, reg_ready_i=1, and a push aligned to the pop cycle -> level stays 16, no overflow, new entry appears last.
- After reset, data write a=1 d=0x7F with no address phase -> pop addr 0x000 data 0x7F. clear_ovf_i asserted in the same cycle as a drop -> overflow_o remains 1.
- rst_i asserted with 5 entries queued and strobe held high -> level 0, valid 0. Strobe stays high after release -> no push until the next low-to-high transition.
